// File: rtl/traffic_light_monitor.sv
// Passive checker for a traffic-light controller: decodes lamps and countdown glyph, flags the first protocol violation.
// Optional violation counter is built when TL_MON_ERRCOUNT_EN is defined; otherwise errCount is tied to zero.
module traffic_light_monitor #(
  parameter int MAX_DWELL = 15,
  parameter int DWELL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [2:0]         inLED,
  input  logic [6:0]         inSS,
  output logic [1:0]         phase,
  output logic [3:0]         digit,
  output logic               digitValid,
  output logic [DWELL_W-1:0] dwell,
  output logic               err,
  output logic [2:0]         errCode,
  output logic [7:0]         errCount
);

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t             state;
  logic               glyph_ok;
  logic [3:0]         glyph_val;
  logic               lamp_ok;
  logic [1:0]         new_phase;
  logic               same_phase;
  logic               order_ok;
  logic               step_bad;
  logic               timeout;
  logic [DWELL_W:0]   dwell_inc;
  logic [DWELL_W-1:0] dwell_sat;
  logic [2:0]         viol_code;
  logic               violation;

  // Active-low segment patterns back to a digit.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'd0;
    case (inSS)
      7'b1000000: glyph_val = 4'd0;
      7'b1111001: glyph_val = 4'd1;
      7'b0100100: glyph_val = 4'd2;
      7'b0110000: glyph_val = 4'd3;
      7'b0011001: glyph_val = 4'd4;
      7'b0010010: glyph_val = 4'd5;
      7'b0000010: glyph_val = 4'd6;
      7'b1111000: glyph_val = 4'd7;
      7'b0000000: glyph_val = 4'd8;
      7'b0010000: glyph_val = 4'd9;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  always_comb begin
    lamp_ok   = 1'b1;
    new_phase = 2'd0;
    case (inLED)
      3'b001:  new_phase = 2'd1;
      3'b010:  new_phase = 2'd2;
      3'b100:  new_phase = 2'd3;
      default: lamp_ok   = 1'b0;
    endcase
  end

  assign same_phase = (new_phase == phase);
  assign order_ok   = (phase == 2'd1 && new_phase == 2'd2) ||
                      (phase == 2'd2 && new_phase == 2'd3) ||
                      (phase == 2'd3 && new_phase == 2'd1);
  // A previous digit of 0 can never be followed by a same-phase step.
  assign step_bad   = glyph_ok && ((digit == 4'd0) || (glyph_val != digit - 4'd1));
  assign dwell_inc  = {1'b0, dwell} + {{DWELL_W{1'b0}}, 1'b1};
  assign timeout    = dwell_inc > (DWELL_W+1)'(MAX_DWELL);
  assign dwell_sat  = (&dwell) ? dwell : dwell_inc[DWELL_W-1:0];

  always_comb begin
    viol_code = 3'd0;
    if (!lamp_ok)                       viol_code = 3'd1;
    else if (!same_phase && !order_ok)  viol_code = 3'd2;
    else if (!glyph_ok)                 viol_code = 3'd3;
    else if (same_phase && step_bad)    viol_code = 3'd4;
    else if (!same_phase && digit != 0) viol_code = 3'd5;
    else if (same_phase && timeout)     viol_code = 3'd6;
  end

  assign violation = (viol_code != 3'd0);

  // Lamp and glyph tracking continue in FAULT; only the checker result is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      phase      <= 2'd0;
      digit      <= 4'd0;
      digitValid <= 1'b0;
      dwell      <= '0;
      err        <= 1'b0;
      errCode    <= 3'd0;
    end else if (tick) begin
      case (state)
        SYNC: begin
          if (lamp_ok && glyph_ok) begin
            phase      <= new_phase;
            digit      <= glyph_val;
            digitValid <= 1'b1;
            dwell      <= '0;
            state      <= TRACK;
          end
        end
        TRACK, FAULT: begin
          if (lamp_ok) begin
            phase <= new_phase;
            dwell <= same_phase ? dwell_sat : '0;
          end else begin
            dwell <= dwell_sat;
          end
          if (glyph_ok) begin
            digit      <= glyph_val;
            digitValid <= 1'b1;
          end else begin
            digitValid <= 1'b0;
          end
          if (state == TRACK && violation) begin
            err     <= 1'b1;
            errCode <= viol_code;
            state   <= FAULT;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

`ifdef TL_MON_ERRCOUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCount <= 8'd0;
    end else if (tick && state != SYNC && violation && errCount != 8'hFF) begin
      errCount <= errCount + 8'd1;
    end
  end
`else
  assign errCount = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor; a behavioural model predicts every output after each driven cycle.
module tb_traffic_light_monitor;

  localparam int MAXD = 3;
  localparam int DW   = 4;
`ifdef TL_MON_ERRCOUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic [2:0]    inLED = 3'b000;
  logic [6:0]    inSS = 7'b1111111;
  logic [1:0]    phase;
  logic [3:0]    digit;
  logic          digitValid;
  logic [DW-1:0] dwell;
  logic          err;
  logic [2:0]    errCode;
  logic [7:0]    errCount;

  typedef struct packed {
    logic [1:0] phase;
    logic [3:0] digit;
    logic       valid;
    logic [3:0] dwell;
    logic       err;
    logic [2:0] code;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int m_state, m_phase, m_digit, m_valid, m_dwell, m_err, m_code, m_cnt;

  traffic_light_monitor #(.MAX_DWELL(MAXD), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .inLED(inLED), .inSS(inSS),
    .phase(phase), .digit(digit), .digitValid(digitValid), .dwell(dwell),
    .err(err), .errCode(errCode), .errCount(errCount)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (glyph(i) == s) return i;
    return -1;
  endfunction

  function automatic bit succ(input int p, input int n);
    return (p == 1 && n == 2) || (p == 2 && n == 3) || (p == 3 && n == 1);
  endfunction

  task automatic modelReset();
    m_state = 0; m_phase = 0; m_digit = 0; m_valid = 0;
    m_dwell = 0; m_err = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic modelStep(input logic [2:0] led, input logic [6:0] ss, input logic tk);
    bit onehot;
    int newph, d, code;
    bit [6:1] hit;
    if (!tk) return;
    onehot = (led == 3'b001) || (led == 3'b010) || (led == 3'b100);
    newph  = (led == 3'b001) ? 1 : (led == 3'b010) ? 2 : (led == 3'b100) ? 3 : 0;
    d      = decode(ss);
    if (m_state == 0) begin
      if (onehot && d >= 0) begin
        m_phase = newph; m_digit = d; m_valid = 1; m_dwell = 0; m_state = 1;
      end
      return;
    end
    hit[1] = !onehot;
    hit[2] = onehot && newph != m_phase && !succ(m_phase, newph);
    hit[3] = d < 0;
    hit[4] = onehot && newph == m_phase && d >= 0 && d != m_digit - 1;
    hit[5] = onehot && newph != m_phase && m_digit != 0;
    hit[6] = onehot && newph == m_phase && m_dwell + 1 > MAXD;
    code = 0;
    for (int i = 1; i <= 6; i++) if (hit[i] && code == 0) code = i;
    if (onehot && newph != m_phase) m_dwell = 0;
    else if (m_dwell < (1 << DW) - 1) m_dwell = m_dwell + 1;
    if (onehot) m_phase = newph;
    if (d >= 0) begin m_digit = d; m_valid = 1; end
    else m_valid = 0;
    if (code != 0) begin
      if (m_state == 1) begin m_err = 1; m_code = code; m_state = 2; end
      if (CNT_EN != 0 && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] led, input logic [6:0] ss, input logic tk);
    exp_t e;
    @(negedge clk);
    inLED = led; inSS = ss; tick = tk;
    modelStep(led, ss, tk);
    sb.push_back('{m_phase[1:0], m_digit[3:0], m_valid[0], m_dwell[3:0], m_err[0], m_code[2:0], m_cnt[7:0]});
    @(posedge clk);
    #1;
    tick = 1'b0;
    e = sb.pop_front();
    checkOutput("phase", 32'(phase), 32'(e.phase));
    checkOutput("digit", 32'(digit), 32'(e.digit));
    checkOutput("digitValid", 32'(digitValid), 32'(e.valid));
    checkOutput("dwell", 32'(dwell), 32'(e.dwell));
    checkOutput("err", 32'(err), 32'(e.err));
    checkOutput("errCode", 32'(errCode), 32'(e.code));
    checkOutput("errCount", 32'(errCount), 32'(e.cnt));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_phase"}, 32'(phase), 0);
    checkOutput({tag, "_digit"}, 32'(digit), 0);
    checkOutput({tag, "_valid"}, 32'(digitValid), 0);
    checkOutput({tag, "_dwell"}, 32'(dwell), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_code"}, 32'(errCode), 0);
    checkOutput({tag, "_cnt"}, 32'(errCount), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    checkZero("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  initial begin
    modelReset();
    doReset();

    // Full legal cycle
    for (int d = 3; d >= 0; d--) applyStimulus(G, glyph(d), 1'b1);
    for (int d = 1; d >= 0; d--) applyStimulus(Y, glyph(d), 1'b1);
    for (int d = 3; d >= 0; d--) applyStimulus(R, glyph(d), 1'b1);
    applyStimulus(G, glyph(3), 1'b1);
    checkOutput("legal_err", 32'(err), 0);

    // Lamp not one-hot, then legal ticks must not change the latched code
    applyStimulus(3'b011, glyph(2), 1'b1);
    checkOutput("lamp_code", 32'(errCode), 1);
    applyStimulus(G, glyph(1), 1'b1);
    applyStimulus(G, glyph(0), 1'b1);
    checkOutput("lamp_hold", 32'(errCode), 1);

    doReset();
    applyStimulus(G, glyph(0), 1'b1);
    applyStimulus(R, glyph(5), 1'b1);
    checkOutput("order_code", 32'(errCode), 2);

    doReset();
    applyStimulus(G, 7'b0010010, 1'b1);
    applyStimulus(G, 7'b0000010, 1'b1);
    checkOutput("step_code", 32'(errCode), 4);

    doReset();
    applyStimulus(G, glyph(3), 1'b1);
    applyStimulus(G, 7'b1111111, 1'b1);
    checkOutput("glyph_code", 32'(errCode), 3);
    checkOutput("glyph_valid", 32'(digitValid), 0);
    checkOutput("glyph_hold", 32'(digit), 3);

    doReset();
    for (int d = 9; d >= 5; d--) applyStimulus(G, glyph(d), 1'b1);
    checkOutput("timeout_code", 32'(errCode), 6);

    // Async reset in the middle of yellow, with tick held high during reset
    doReset();
    applyStimulus(G, glyph(0), 1'b1);
    applyStimulus(Y, glyph(1), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b1;
    modelReset();
    #1;
    checkZero("async");
    @(posedge clk);
    #1;
    checkZero("tickrst");
    @(negedge clk);
    rst = 1'b0;
    tick = 1'b0;

    // Inputs toggling with tick low must be ignored
    applyStimulus(G, glyph(3), 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 1'b0);

    applyStimulus(3'b000, glyph(2), 1'b1);
    applyStimulus(3'b011, glyph(1), 1'b1);
    applyStimulus(3'b101, glyph(0), 1'b1);
    checkOutput("errcount3", 32'(errCount), 32'(CNT_EN * 3));
    checkOutput("errcount_code", 32'(errCode), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
